// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
package fifo_rd_pkg;

    localparam int FIFO_WIDTH_DEF = 16;

    typedef logic [FIFO_WIDTH_DEF-1:0] data_t;

    // Pointer width for a skid buffer of the given depth (at least one bit).
    function automatic int skid_ptr_w(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Small circular buffer with push at the tail, pop at the head and an occupancy count.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH_DEF,
    parameter int DEPTH = 3,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occ
);

    localparam int PTR_W = skid_ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push) begin
            mem_d[tail_q] = push_data;
            tail_d        = ptr_inc(tail_q);
        end else begin
            tail_d = tail_q;
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // State registers; reset clears storage so the head reads as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            head_q <= {PTR_W{1'b0}};
            tail_q <= {PTR_W{1'b0}};
            occ_q  <= {OCC_W{1'b0}};
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign occ       = occ_q;

endmodule

// File: rtl/fifo_rd_adapter.sv
// Drains a synchronous FIFO read port into a valid/ready stream, hiding the
// one-cycle read latency behind a credit-controlled skid buffer.
module fifo_rd_adapter
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int SKID_DEPTH = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  underflow_err
);

    localparam int OCC_W = $clog2(SKID_DEPTH + 1);
    localparam logic [OCC_W:0] CREDIT_LIMIT = (OCC_W + 1)'(SKID_DEPTH);

    logic [OCC_W-1:0]     occ_s;
    logic [OCC_W:0]       used_s;
    logic                 rd_en_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] rd_count_q, rd_count_d;
    logic                 underflow_err_q, underflow_err_d;

    // Issue a read only when a skid slot is guaranteed for the returning word;
    // m_ready is deliberately absent from this path.
    always_comb begin
        used_s = {1'b0, occ_s} + {{OCC_W{1'b0}}, inflight_q};
        if (rst) begin
            rd_en_s = 1'b0;
        end else begin
            rd_en_s = enable && !fifo_empty && (used_s < CREDIT_LIMIT);
        end
    end

    // Capture, pop, delivered-word count and sticky underflow.
    always_comb begin
        inflight_d = rd_en_s;
        push_s     = inflight_q && !fifo_underflow;
        pop_s      = m_valid && m_ready;
        if (pop_s) begin
            rd_count_d = rd_count_q + CNT_WIDTH'(1);
        end else begin
            rd_count_d = rd_count_q;
        end
        if (inflight_q && fifo_underflow) begin
            underflow_err_d = 1'b1;
        end else begin
            underflow_err_d = underflow_err_q;
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q      <= 1'b0;
            rd_count_q      <= {CNT_WIDTH{1'b0}};
            underflow_err_q <= 1'b0;
        end else begin
            inflight_q      <= inflight_d;
            rd_count_q      <= rd_count_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    fifo_rd_skid #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (fifo_data_out),
        .pop       (pop_s),
        .head_data (m_data),
        .occ       (occ_s)
    );

    assign fifo_rd_en    = rd_en_s;
    assign m_valid       = (occ_s != {OCC_W{1'b0}});
    assign rd_count      = rd_count_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Scoreboard bench for fifo_rd_adapter with a behavioural FIFO read-port model.
module tb_fifo_rd_adapter;
    import fifo_rd_pkg::*;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          fifo_rd_en;
    data_t         fifo_data_out;
    logic          fifo_empty;
    logic          fifo_underflow;
    logic          m_valid;
    logic          m_ready;
    data_t         m_data;
    logic [CW-1:0] rd_count;
    logic          underflow_err;

    always #5 clk = ~clk;

    fifo_rd_adapter #(
        .FIFO_WIDTH (16),
        .SKID_DEPTH (3),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .rd_count       (rd_count),
        .underflow_err  (underflow_err)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    data_t fq[$];
    data_t exp_q[$];
    logic  force_empty;
    int    uf_at, rd_idx, cyc, pops;
    int    rd_n, rd_first, rd_last, v_n, v_first, v_last;
    logic  prev_hold;
    data_t prev_data;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic upd_empty();
        fifo_empty = (fq.size() == 0) || force_empty;
    endtask

    task automatic clr_stats();
        rd_n = 0; rd_first = 0; rd_last = 0;
        v_n  = 0; v_first  = 0; v_last  = 0;
    endtask

    task automatic preload(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            fq.push_back(data_t'(base + i));
        end
        upd_empty();
    endtask

    // One clock: sample at negedge, then advance the FIFO model just after posedge.
    task automatic tick();
        logic  rd;
        data_t w;
        @(negedge clk);
        rd = fifo_rd_en;
        check_val("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 32'd0);
        if (prev_hold) begin
            check_val("hold_valid", 32'(m_valid), 32'd1);
            check_val("hold_data", 32'(m_data), 32'(prev_data));
        end
        prev_hold = m_valid && !m_ready;
        prev_data = m_data;
        if (rd) begin
            if (rd_n == 0) rd_first = cyc;
            rd_last = cyc;
            rd_n++;
        end
        if (m_valid) begin
            if (v_n == 0) v_first = cyc;
            v_last = cyc;
            v_n++;
        end
        if (m_valid && m_ready) begin
            pops++;
            check_val("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                check_val("data", 32'(m_data), 32'(w));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        fifo_underflow = 1'b0;
        fifo_data_out  = 16'hDEAD;
        if (rd && fq.size() > 0) begin
            w = fq.pop_front();
            rd_idx++;
            fifo_data_out = w;
            if (rd_idx == uf_at) begin
                fifo_underflow = 1'b1;
            end else begin
                exp_q.push_back(w);
            end
        end
        upd_empty();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fq.delete();
        exp_q.delete();
        force_empty = 1'b0;
        uf_at = 0; rd_idx = 0; pops = 0;
        fifo_underflow = 1'b0;
        fifo_data_out  = 16'h0000;
        prev_hold = 1'b0;
        upd_empty();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic check_zero_outputs(input string pfx);
        check_val({pfx, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
        check_val({pfx, "_m_valid"}, 32'(m_valid), 32'd0);
        check_val({pfx, "_m_data"}, 32'(m_data), 32'd0);
        check_val({pfx, "_rd_count"}, 32'(rd_count), 32'd0);
        check_val({pfx, "_uf_err"}, 32'(underflow_err), 32'd0);
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; m_ready = 1'b0; force_empty = 1'b0;
        fifo_underflow = 1'b0; fifo_data_out = 16'h0000;
        cyc = 0; uf_at = 0; rd_idx = 0; pops = 0; prev_hold = 1'b0; prev_data = 16'h0000;
        clr_stats();
        upd_empty();
        #2 rst = 1'b1;
        #1 check_zero_outputs("por");
        do_reset();

        // Empty FIFO: no reads
        enable = 1'b1; m_ready = 1'b1;
        clr_stats();
        run(5);
        check_val("empty_rd_n", 32'(rd_n), 32'd0);

        // Single word
        do_reset(); clr_stats();
        fq.push_back(16'hA5A5); upd_empty();
        run(6);
        check_val("single_rd_n", 32'(rd_n), 32'd1);
        check_val("single_v_n", 32'(v_n), 32'd1);
        check_val("single_latency", 32'(v_first - rd_first), 32'd2);
        check_val("single_rd_count", 32'(rd_count), 32'd1);
        check_val("single_sb_empty", 32'(exp_q.size()), 32'd0);

        // Streaming 1..8
        do_reset(); clr_stats();
        preload(8, 1);
        run(14);
        check_val("stream_rd_n", 32'(rd_n), 32'd8);
        check_val("stream_rd_span", 32'(rd_last - rd_first), 32'd7);
        check_val("stream_v_n", 32'(v_n), 32'd8);
        check_val("stream_v_span", 32'(v_last - v_first), 32'd7);
        check_val("stream_latency", 32'(v_first - rd_first), 32'd2);
        check_val("stream_rd_count", 32'(rd_count), 32'd8);
        check_val("stream_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure
        do_reset(); clr_stats();
        m_ready = 1'b0;
        preload(8, 1);
        run(8);
        check_val("bp_rd_n", 32'(rd_n), 32'd3);
        check_val("bp_valid", 32'(m_valid), 32'd1);
        check_val("bp_data", 32'(m_data), 32'd1);
        check_val("bp_rd_count", 32'(rd_count), 32'd0);
        m_ready = 1'b1;
        clr_stats();
        run(15);
        check_val("bp_drain_v_n", 32'(v_n), 32'd8);
        check_val("bp_drain_v_span", 32'(v_last - v_first), 32'd7);
        check_val("bp_drain_rd_n", 32'(rd_n), 32'd5);
        check_val("bp_rd_count_final", 32'(rd_count), 32'd8);
        check_val("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Underflow on the third returned word
        do_reset(); clr_stats();
        uf_at = 3;
        preload(6, 1);
        run(6);
        check_val("uf_err_set", 32'(underflow_err), 32'd1);
        run(8);
        check_val("uf_err_sticky", 32'(underflow_err), 32'd1);
        check_val("uf_rd_count", 32'(rd_count), 32'd5);
        check_val("uf_pops", 32'(pops), 32'd5);
        check_val("uf_sb_empty", 32'(exp_q.size()), 32'd0);
        do_reset();
        check_val("uf_err_cleared", 32'(underflow_err), 32'd0);

        // Enable low, then empty flag toggling
        enable = 1'b0;
        clr_stats();
        preload(12, 16'h0100);
        run(5);
        check_val("dis_rd_n", 32'(rd_n), 32'd0);
        check_val("dis_valid", 32'(m_valid), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            force_empty = 1'($urandom_range(0, 1));
            upd_empty();
            tick();
        end
        force_empty = 1'b0;
        upd_empty();
        run(20);
        check_val("tog_rd_count", 32'(rd_count), 32'd12);
        check_val("tog_sb_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-cycle with a word in flight
        do_reset(); clr_stats();
        preload(10, 16'h0200);
        run(5);
        check_val("mid_pre_rd_count", 32'(rd_count), 32'd3);
        check_val("mid_pre_rd_en", 32'(fifo_rd_en), 32'd1);
        #2 rst = 1'b1;
        #1 check_zero_outputs("mid");
        do_reset(); clr_stats();
        run(5);
        check_val("post_rst_rd_n", 32'(rd_n), 32'd0);
        check_val("post_rst_v_n", 32'(v_n), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
